// File: rtl/bank_word_encoder_pkg.sv
// ============================================================================
// bank_word_encoder_pkg : shared sizes, state encoding and index helper
// Revision: 1.0
// ============================================================================
`default_nettype none

package bank_word_encoder_pkg;

    localparam int SEL_W       = 10;
    localparam int WORDS       = 2 ** SEL_W;
    localparam int CHUNK_W     = 32;
    localparam int NCHUNK      = WORDS / CHUNK_W;
    localparam int CHUNK_IDX_W = $clog2(CHUNK_W);
    localparam int CHUNK_PTR_W = $clog2(NCHUNK);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_EMIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Chunks are power-of-two aligned, so the line index is a plain concatenation.
    function automatic logic [SEL_W-1:0] make_index(
        input logic [CHUNK_PTR_W-1:0] ptr,
        input logic [CHUNK_IDX_W-1:0] bit_idx
    );
        return {ptr, bit_idx};
    endfunction

endpackage

`default_nettype wire

// File: rtl/bank_word_encoder_chunk_priority_encoder.sv
// ============================================================================
// chunk_priority_encoder : lowest-set-bit index of one chunk, plus found flag
// Revision: 1.0
// ============================================================================
`default_nettype none

module chunk_priority_encoder #(
    parameter int CHUNK_W = 32
) (
    input  logic [CHUNK_W-1:0]         bits,
    output logic [$clog2(CHUNK_W)-1:0] index,
    output logic                       found
);

    localparam int IDX_W = $clog2(CHUNK_W);

    // Walk from the top down so the last hit written is the lowest set bit.
    always_comb begin
        index = '0;
        found = |bits;
        for (int i = CHUNK_W - 1; i >= 0; i--) begin
            if (bits[i]) begin
                index = IDX_W'(i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/bank_word_encoder.sv
// ============================================================================
// bank_word_encoder : serially encodes every set word line into its index,
//                     ascending, one chunk examined per cycle
// Revision: 1.0
// ============================================================================
`default_nettype none

module bank_word_encoder
    import bank_word_encoder_pkg::*;
(
`ifdef USE_POWER_PINS
    inout  wire               vccd1,
    inout  wire               vssd1,
`endif
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [WORDS-1:0]  lines,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SEL_W-1:0]  out_index,
    output logic              out_last,
    output logic              done,
    output logic              none,
    output logic [SEL_W:0]    count
);

    localparam logic [CHUNK_PTR_W-1:0] CHUNK_LAST = CHUNK_PTR_W'(NCHUNK - 1);
    localparam logic [SEL_W:0]         COUNT_ONE  = {{SEL_W{1'b0}}, 1'b1};
    localparam logic [WORDS-1:0]       WORD_ONE   = {{(WORDS-1){1'b0}}, 1'b1};

    state_t                   r_state;
    logic [WORDS-1:0]         r_pending;
    logic [CHUNK_PTR_W-1:0]   r_chunk;
    logic                     r_out_valid;
    logic [SEL_W-1:0]         r_out_index;
    logic                     r_out_last;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_none;
    logic [SEL_W:0]           r_count;

    logic [CHUNK_W-1:0]       w_chunk_bits;
    logic [CHUNK_IDX_W-1:0]   w_bit_idx;
    logic                     w_found;
    logic [SEL_W-1:0]         w_scan_index;
    logic [WORDS-1:0]         w_clear_mask;
    logic                     w_last;
    logic                     w_handshake;

    assign w_chunk_bits = r_pending[{r_chunk, {CHUNK_IDX_W{1'b0}}} +: CHUNK_W];

    chunk_priority_encoder #(
        .CHUNK_W (CHUNK_W)
    ) u_chunk_pe (
        .bits    (w_chunk_bits),
        .index   (w_bit_idx),
        .found   (w_found)
    );

    assign w_scan_index = make_index(r_chunk, w_bit_idx);
    assign w_clear_mask = WORD_ONE << w_scan_index;
    // Last when nothing else remains anywhere in the vector once this line is gone.
    assign w_last       = ~|(r_pending & ~w_clear_mask);
    assign w_handshake  = r_out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_pending   <= '0;
            r_chunk     <= '0;
            r_out_valid <= 1'b0;
            r_out_index <= '0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_none      <= 1'b0;
            r_count     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (load) begin
                        r_pending <= lines;
                        r_chunk   <= '0;
                        r_count   <= '0;
                        r_none    <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= ST_SCAN;
                    end
                end

                ST_SCAN: begin
                    if (w_found) begin
                        r_out_index <= w_scan_index;
                        r_out_valid <= 1'b1;
                        r_out_last  <= w_last;
                        r_state     <= ST_EMIT;
                    end else if (r_chunk == CHUNK_LAST) begin
                        r_done  <= 1'b1;
                        r_none  <= (r_count == '0);
                        r_state <= ST_DONE;
                    end else begin
                        r_chunk <= r_chunk + 1'b1;
                    end
                end

                ST_EMIT: begin
                    // Rescan the same chunk: it may hold further set lines.
                    if (w_handshake) begin
                        r_pending[r_out_index] <= 1'b0;
                        r_count     <= r_count + COUNT_ONE;
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        r_state     <= ST_SCAN;
                    end
                end

                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign out_valid = r_out_valid;
    assign out_index = r_out_index;
    assign out_last  = r_out_last;
    assign done      = r_done;
    assign none      = r_none;
    assign count     = r_count;

endmodule

`default_nettype wire

// File: tb/tb_bank_word_encoder.sv
// ============================================================================
// tb_bank_word_encoder : directed self-checking bench for bank_word_encoder
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_bank_word_encoder;

    logic          clk;
    logic          rst_n;
    logic          load;
    logic [1023:0] lines;
    logic          busy;
    logic          out_valid;
    logic          out_ready;
    logic [9:0]    out_index;
    logic          out_last;
    logic          done;
    logic          none;
    logic [10:0]   count;

    int vectors;
    int miscompares;

    int idx_q[$];
    bit last_q[$];
    int done_cyc;
    int first_valid_cyc;
    int stall_changes;
    int done_pulses;

    bank_word_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .lines     (lines),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_index (out_index),
        .out_last  (out_last),
        .done      (done),
        .none      (none),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Leaves the caller at the falling edge right after the load edge (cycle 1).
    task automatic do_load(input logic [1023:0] v);
        @(negedge clk);
        lines = v;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
    endtask

    // Cycle k is observed at the falling edge after load edge N+k-1, i.e. the
    // value a consumer samples at edge N+k. mode 0: ready always; mode 1: toggling.
    task automatic run_scan(input int mode, input int limit);
        int       cyc;
        bit       held;
        bit [9:0] held_idx;
        bit       held_last;
        idx_q.delete();
        last_q.delete();
        done_cyc        = -1;
        first_valid_cyc = -1;
        stall_changes   = 0;
        done_pulses     = 0;
        held            = 1'b0;
        held_idx        = '0;
        held_last       = 1'b0;
        cyc             = 1;
        while (cyc <= limit) begin
            out_ready = (mode == 0) ? 1'b1 : cyc[0];
            if (done) begin
                done_pulses++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (out_valid) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (held && (out_index != held_idx || out_last != held_last)) stall_changes++;
                if (out_ready) begin
                    idx_q.push_back(int'(out_index));
                    last_q.push_back(out_last);
                    held = 1'b0;
                end else begin
                    held      = 1'b1;
                    held_idx  = out_index;
                    held_last = out_last;
                end
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({busy, out_valid, out_last, done, none} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got %b expected 00000", {busy, out_valid, out_last, done, none});
        end
        vectors++;
        if (out_index !== 10'd0 || count !== 11'd0) begin
            miscompares++;
            $display("FAIL reset_index_count: got idx=%0d cnt=%0d expected 0/0", out_index, count);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_one_hot;
        logic [1023:0] v;
        v = '0;
        v[10'h2A5] = 1'b1;
        do_load(v);
        run_scan(0, 200);
        vectors++;
        if (done_cyc !== 35) begin
            miscompares++;
            $display("FAIL onehot_done_cycle: got %0d expected 35", done_cyc);
        end
        vectors++;
        if (first_valid_cyc !== 23) begin
            miscompares++;
            $display("FAIL onehot_first_valid: got %0d expected 23", first_valid_cyc);
        end
        vectors++;
        if (idx_q.size() !== 1 || (idx_q.size() == 1 && (idx_q[0] !== 'h2A5 || last_q[0] !== 1'b1))) begin
            miscompares++;
            $display("FAIL onehot_index: got n=%0d first=%0h expected n=1 idx=2a5 last=1",
                     idx_q.size(), (idx_q.size() > 0) ? idx_q[0] : -1);
        end
        vectors++;
        if (count !== 11'd1 || none !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL onehot_status: got cnt=%0d none=%b busy=%b expected 1/0/0", count, none, busy);
        end
        vectors++;
        if (done_pulses !== 1) begin
            miscompares++;
            $display("FAIL onehot_done_pulse: got %0d expected 1", done_pulses);
        end
    endtask

    task automatic test_stall_order;
        logic [1023:0] v;
        int exp_idx[4];
        bit exp_last[4];
        int bad;
        exp_idx  = '{3, 31, 32, 1023};
        exp_last = '{1'b0, 1'b0, 1'b0, 1'b1};
        v = '0;
        v[3] = 1'b1; v[31] = 1'b1; v[32] = 1'b1; v[1023] = 1'b1;
        do_load(v);
        run_scan(1, 400);
        vectors++;
        if (first_valid_cyc !== 2) begin
            miscompares++;
            $display("FAIL stall_first_latency: got %0d expected 2", first_valid_cyc);
        end
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (i >= idx_q.size()) bad++;
            else if (idx_q[i] != exp_idx[i] || last_q[i] != exp_last[i]) bad++;
        end
        vectors++;
        if (bad !== 0 || idx_q.size() !== 4) begin
            miscompares++;
            $display("FAIL stall_sequence: got %0d wrong of n=%0d expected 0 wrong of 4", bad, idx_q.size());
        end
        vectors++;
        if (stall_changes !== 0) begin
            miscompares++;
            $display("FAIL stall_hold: got %0d changes expected 0", stall_changes);
        end
        vectors++;
        if (count !== 11'd4 || none !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_count: got cnt=%0d none=%b expected 4/0", count, none);
        end
    endtask

    task automatic test_all_zero;
        do_load('0);
        run_scan(0, 100);
        vectors++;
        if (done_cyc !== 33) begin
            miscompares++;
            $display("FAIL zero_done_cycle: got %0d expected 33", done_cyc);
        end
        vectors++;
        if (first_valid_cyc !== -1) begin
            miscompares++;
            $display("FAIL zero_no_valid: got first valid at %0d expected never", first_valid_cyc);
        end
        vectors++;
        if (none !== 1'b1 || count !== 11'd0 || done_pulses !== 1) begin
            miscompares++;
            $display("FAIL zero_status: got none=%b cnt=%0d pulses=%0d expected 1/0/1", none, count, done_pulses);
        end
    endtask

    task automatic test_all_ones;
        int bad;
        do_load('1);
        run_scan(0, 3000);
        vectors++;
        if (done_cyc < 0) begin
            miscompares++;
            $display("FAIL ones_done_timeout: got no done expected done within 3000");
        end
        bad = 0;
        for (int i = 0; i < idx_q.size(); i++) begin
            if (idx_q[i] != i || last_q[i] != (i == 1023)) bad++;
        end
        vectors++;
        if (bad !== 0 || idx_q.size() !== 1024) begin
            miscompares++;
            $display("FAIL ones_sequence: got %0d wrong of n=%0d expected 0 wrong of 1024", bad, idx_q.size());
        end
        vectors++;
        if (count !== 11'd1024 || none !== 1'b0) begin
            miscompares++;
            $display("FAIL ones_count: got cnt=%0d none=%b expected 1024/0", count, none);
        end
    endtask

    task automatic test_reload_ignored;
        logic [1023:0] a;
        logic [1023:0] b;
        a = '0; a[10] = 1'b1; a[700] = 1'b1;
        b = '0; b[20] = 1'b1; b[40] = 1'b1;
        do_load(a);
        repeat (2) @(negedge clk);
        lines = b;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        run_scan(0, 200);
        vectors++;
        if (idx_q.size() !== 2 || (idx_q.size() == 2 && (idx_q[0] !== 10 || idx_q[1] !== 700 ||
            last_q[0] !== 1'b0 || last_q[1] !== 1'b1))) begin
            miscompares++;
            $display("FAIL reload_sequence: got n=%0d first=%0d expected 10,700 with last on 700",
                     idx_q.size(), (idx_q.size() > 0) ? idx_q[0] : -1);
        end
        vectors++;
        if (count !== 11'd2) begin
            miscompares++;
            $display("FAIL reload_count: got %0d expected 2", count);
        end
    endtask

    task automatic test_reset_mid_emit;
        logic [1023:0] v;
        int waited;
        v = '0; v[5] = 1'b1; v[100] = 1'b1; v[900] = 1'b1;
        out_ready = 1'b0;
        do_load(v);
        waited = 0;
        while (!out_valid && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        vectors++;
        if (out_valid !== 1'b1 || out_index !== 10'd5) begin
            miscompares++;
            $display("FAIL midrst_pre_emit: got valid=%b idx=%0d expected 1/5", out_valid, out_index);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({busy, out_valid, out_last, done, none} !== 5'b0 || out_index !== 10'd0 || count !== 11'd0) begin
            miscompares++;
            $display("FAIL midrst_outputs: got flags=%b idx=%0d cnt=%0d expected all 0",
                     {busy, out_valid, out_last, done, none}, out_index, count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        v = '0; v[77] = 1'b1;
        do_load(v);
        run_scan(0, 200);
        vectors++;
        if (idx_q.size() !== 1 || (idx_q.size() == 1 && (idx_q[0] !== 77 || last_q[0] !== 1'b1)) ||
            count !== 11'd1) begin
            miscompares++;
            $display("FAIL midrst_reload: got n=%0d cnt=%0d expected single 77 and cnt=1", idx_q.size(), count);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        load        = 1'b0;
        lines       = '0;
        out_ready   = 1'b0;
        test_reset();
        test_one_hot();
        test_stall_order();
        test_all_zero();
        test_all_ones();
        test_reload_ignored();
        test_reset_mid_emit();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
